// File: rtl/bitop_pkg.sv
// -----------------------------------------------------------------------------
// bitop_pkg
// Shared definitions for the bitop_pipe block.
//   OP_W            : width of the operation select field
//   op_t            : operation select type
//   OP_XOR..OP_ACC_CLR : legal operation encodings (6 and 7 are illegal)
//   popcount()      : population count helper, used only when the
//                     BITOP_PIPE_POPCNT_EN build option is enabled
// -----------------------------------------------------------------------------
package bitop_pkg;

  localparam int OP_W = 3;

  typedef logic [OP_W-1:0] op_t;

  localparam op_t OP_XOR     = 3'd0;
  localparam op_t OP_AND     = 3'd1;
  localparam op_t OP_OR      = 3'd2;
  localparam op_t OP_XNOR    = 3'd3;
  localparam op_t OP_ACC     = 3'd4;
  localparam op_t OP_ACC_CLR = 3'd5;

  // Counts the set bits of a word zero-extended to 32 bits.
  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      cnt += 32'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/bitop_alu.sv
// -----------------------------------------------------------------------------
// bitop_alu
// Purely combinational bitwise operation unit.
// Parameters:
//   WIDTH    : operand/result width (1..32)
//   ACC_INIT : value the accumulator returns to on ACC_CLR
// Ports:
//   a, b     : operands
//   op       : operation select (bitop_pkg encodings)
//   acc      : current accumulator value
//   y        : result (0 for illegal ops)
//   err      : 1 for illegal op encodings
//   next_acc : accumulator value to load if this op is accepted
// -----------------------------------------------------------------------------
module bitop_alu
  import bitop_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_t              op,
  input  logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] y,
  output logic             err,
  output logic [WIDTH-1:0] next_acc
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a value unassigned; otherwise synthesis would infer latches.
    y        = '0;
    err      = 1'b0;
    next_acc = acc;
    case (op)
      OP_XOR:  y = a ^ b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XNOR: y = ~(a ^ b);
      OP_ACC: begin
        next_acc = acc ^ a ^ b;
        y        = acc ^ a ^ b;
      end
      OP_ACC_CLR: begin
        // Report the value being cleared, then restart from ACC_INIT.
        y        = acc;
        next_acc = ACC_INIT;
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/bitop_pipe.sv
// -----------------------------------------------------------------------------
// bitop_pipe
// One-stage valid/ready pipeline around bitop_alu with an XOR accumulator.
// Build option: define BITOP_PIPE_POPCNT_EN to add the out_pop output
// (registered population count of out_y).
// Parameters:
//   WIDTH    : operand/result width (1..32)
//   ACC_INIT : accumulator value after reset and after ACC_CLR
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : input handshake; in_ready = ~out_valid | out_ready
//   in_a, in_b, in_op : operands and operation select
//   out_valid/out_ready : output handshake
//   out_y             : registered result
//   out_oe            : registered in_a & in_b of the producing transfer
//   out_pop           : (BITOP_PIPE_POPCNT_EN only) popcount of out_y
//   out_err           : registered illegal-op flag
// -----------------------------------------------------------------------------
module bitop_pipe
  import bitop_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_a,
  input  logic [WIDTH-1:0]             in_b,
  input  op_t                          in_op,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_y,
  output logic [WIDTH-1:0]             out_oe,
`ifdef BITOP_PIPE_POPCNT_EN
  output logic [$clog2(WIDTH+1)-1:0]   out_pop,
`endif
  output logic                         out_err
);

  logic             in_xfer;
  logic             out_xfer;
  logic [WIDTH-1:0] alu_y;
  logic             alu_err;
  logic [WIDTH-1:0] alu_next_acc;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_y_q,     out_y_d;
  logic [WIDTH-1:0] out_oe_q,    out_oe_d;
  logic             out_err_q,   out_err_d;
  logic [WIDTH-1:0] acc_q,       acc_d;

`ifdef BITOP_PIPE_POPCNT_EN
  localparam int POP_W = $clog2(WIDTH + 1);
  logic [POP_W-1:0] out_pop_q, out_pop_d;
`endif

  // The output register can take a new word when it is empty or is being
  // drained this same cycle, so continuous flow has no bubble.
  assign in_ready = ~out_valid_q | out_ready;
  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid_q & out_ready;

  bitop_alu #(
    .WIDTH    (WIDTH),
    .ACC_INIT (ACC_INIT)
  ) u_alu (
    .a        (in_a),
    .b        (in_b),
    .op       (in_op),
    .acc      (acc_q),
    .y        (alu_y),
    .err      (alu_err),
    .next_acc (alu_next_acc)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    out_y_d     = out_y_q;
    out_oe_d    = out_oe_q;
    out_err_d   = out_err_q;
    acc_d       = acc_q;
`ifdef BITOP_PIPE_POPCNT_EN
    out_pop_d   = out_pop_q;
`endif
    if (in_xfer) begin
      // Covers both the empty case and the simultaneous drain-and-refill.
      out_valid_d = 1'b1;
      out_y_d     = alu_y;
      out_oe_d    = in_a & in_b;
      out_err_d   = alu_err;
      acc_d       = alu_next_acc;
`ifdef BITOP_PIPE_POPCNT_EN
      out_pop_d   = POP_W'(popcount(32'(alu_y)));
`endif
    end else if (out_xfer) begin
      // Data fields hold; only the valid flag drops.
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (rst) begin
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      out_oe_q    <= '0;
      out_err_q   <= 1'b0;
      acc_q       <= ACC_INIT;
`ifdef BITOP_PIPE_POPCNT_EN
      out_pop_q   <= '0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_y_q     <= out_y_d;
      out_oe_q    <= out_oe_d;
      out_err_q   <= out_err_d;
      acc_q       <= acc_d;
`ifdef BITOP_PIPE_POPCNT_EN
      out_pop_q   <= out_pop_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;
  assign out_oe    = out_oe_q;
  assign out_err   = out_err_q;
`ifdef BITOP_PIPE_POPCNT_EN
  assign out_pop   = out_pop_q;
`endif

endmodule

// File: tb/tb_bitop_pipe.sv
// -----------------------------------------------------------------------------
// tb_bitop_pipe
// Self-checking bench for bitop_pipe (WIDTH=8, ACC_INIT=0). Expected results
// are queued when an input transfer is committed and popped when the DUT
// hands the result out. With BITOP_PIPE_POPCNT_EN defined, out_pop is also
// checked and a WIDTH=16 instance exercises the popcount example.
// -----------------------------------------------------------------------------
module tb_bitop_pipe;
  import bitop_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  op_t          in_op = OP_XOR;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_y;
  logic [W-1:0] out_oe;
  logic         out_err;
`ifdef BITOP_PIPE_POPCNT_EN
  logic [$clog2(W+1)-1:0] out_pop;
`endif

  always #5 clk = ~clk;

  bitop_pipe #(
    .WIDTH    (W),
    .ACC_INIT (8'h00)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_oe    (out_oe),
`ifdef BITOP_PIPE_POPCNT_EN
    .out_pop   (out_pop),
`endif
    .out_err   (out_err)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    op_t          op;
    logic [W-1:0] y;
    logic [W-1:0] oe;
    logic         err;
  } vec_t;

  typedef struct {
    logic [W-1:0] y;
    logic [W-1:0] oe;
    logic         err;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Present a word at the falling edge and wait (bounded) until it is
  // accepted; the expected result is queued when acceptance is certain.
  task automatic send(input vec_t v, output int stalls);
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = v.a;
    in_b     = v.b;
    in_op    = v.op;
    stalls   = 0;
    #1;
    while (!in_ready && stalls < 50) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    if (in_ready) begin
      e.y = v.y; e.oe = v.oe; e.err = v.err;
      sb.push_back(e);
    end else begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stuck at 0, expected 1");
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Output monitor: compares the held result whenever it is handed out.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_out: got y=0x%0h, expected no result", out_y);
      end else begin
        e = sb.pop_front();
        check("out_y",   32'(out_y),   32'(e.y));
        check("out_oe",  32'(out_oe),  32'(e.oe));
        check("out_err", 32'(out_err), 32'(e.err));
`ifdef BITOP_PIPE_POPCNT_EN
        check("out_pop", 32'(out_pop), 32'($countones(e.y)));
`endif
      end
    end
  end

`ifdef BITOP_PIPE_POPCNT_EN
  logic          p_valid = 1'b0;
  logic          p_ready;
  logic [15:0]   p_a = '0;
  logic [15:0]   p_b = '0;
  op_t           p_op = OP_XOR;
  logic          p_ovalid;
  logic [15:0]   p_y;
  logic [15:0]   p_oe;
  logic [4:0]    p_pop;
  logic          p_err;

  bitop_pipe #(
    .WIDTH    (16),
    .ACC_INIT (16'h0000)
  ) u_dut16 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (p_valid),
    .in_ready  (p_ready),
    .in_a      (p_a),
    .in_b      (p_b),
    .in_op     (p_op),
    .out_valid (p_ovalid),
    .out_ready (1'b1),
    .out_y     (p_y),
    .out_oe    (p_oe),
    .out_pop   (p_pop),
    .out_err   (p_err)
  );
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   stalls;
    int   total_stalls;
    vec_t v;

    vecs[0]  = '{8'h5A, 8'h0F, OP_XOR,     8'h55, 8'h0A, 1'b0};
    vecs[1]  = '{8'hF0, 8'h3C, OP_AND,     8'h30, 8'h30, 1'b0};
    vecs[2]  = '{8'hF0, 8'h0F, OP_OR,      8'hFF, 8'h00, 1'b0};
    vecs[3]  = '{8'hAA, 8'h0F, OP_XNOR,    8'h5A, 8'h0A, 1'b0};
    vecs[4]  = '{8'h01, 8'h00, OP_ACC,     8'h01, 8'h00, 1'b0};
    vecs[5]  = '{8'h03, 8'h00, OP_ACC,     8'h02, 8'h00, 1'b0};
    vecs[6]  = '{8'h00, 8'h00, OP_ACC_CLR, 8'h02, 8'h00, 1'b0};
    vecs[7]  = '{8'h10, 8'h00, OP_ACC,     8'h10, 8'h00, 1'b0};
    vecs[8]  = '{8'hFF, 8'hF0, 3'd6,       8'h00, 8'hF0, 1'b1};
    vecs[9]  = '{8'h12, 8'h34, 3'd7,       8'h00, 8'h10, 1'b1};
    vecs[10] = '{8'h00, 8'h00, OP_ACC,     8'h10, 8'h00, 1'b0};
    vecs[11] = '{8'h00, 8'h00, OP_ACC_CLR, 8'h10, 8'h00, 1'b0};
    vecs[12] = '{8'h00, 8'h00, OP_ACC_CLR, 8'h00, 8'h00, 1'b0};
    vecs[13] = '{8'h3C, 8'h00, OP_ACC,     8'h3C, 8'h00, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_y",     32'(out_y),     32'd0);
    check("rst_out_oe",    32'(out_oe),    32'd0);
    check("rst_out_err",   32'(out_err),   32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);

    // Back-to-back table with a free-running consumer: never stalls.
    total_stalls = 0;
    for (int i = 0; i < 14; i++) begin
      send(vecs[i], stalls);
      total_stalls += stalls;
    end
    idle();
    check("no_bubble_stalls", 32'(total_stalls), 32'd0);
    repeat (2) @(negedge clk);
    #1;
    check("drained_out_valid", 32'(out_valid), 32'd0);

    // Backpressure: held word stays put, next word waits, acc untouched.
    @(negedge clk);
    out_ready = 1'b0;
    v = '{8'h01, 8'h00, OP_ACC, 8'h3D, 8'h00, 1'b0};
    send(v, stalls);
    @(negedge clk);
    in_a = 8'h02; in_b = 8'h04; in_op = OP_ACC;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_in_ready",  32'(in_ready),  32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_out_y",     32'(out_y),     32'h3D);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", 32'(in_ready), 32'd1);
    begin
      exp_t e;
      e.y = 8'h3B; e.oe = 8'h00; e.err = 1'b0;
      if (in_ready) sb.push_back(e);
    end
    v = '{8'h00, 8'h00, OP_ACC_CLR, 8'h3B, 8'h00, 1'b0};
    send(v, stalls);
    idle();

    // Reset while a result is held and the accumulator is non-zero.
    v = '{8'h3C, 8'h00, OP_ACC, 8'h3C, 8'h00, 1'b0};
    @(negedge clk);
    out_ready = 1'b0;
    send(v, stalls);
    idle();
    #1;
    check("pre_rst_out_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_y",     32'(out_y),     32'd0);
    check("mid_rst_out_oe",    32'(out_oe),    32'd0);
    check("mid_rst_out_err",   32'(out_err),   32'd0);
    check("mid_rst_in_ready",  32'(in_ready),  32'd1);
    out_ready = 1'b1;
    v = '{8'h00, 8'h00, OP_ACC_CLR, 8'h00, 8'h00, 1'b0};
    send(v, stalls);
    idle();
    repeat (3) @(negedge clk);
    #1;
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

`ifdef BITOP_PIPE_POPCNT_EN
    @(negedge clk);
    p_valid = 1'b1; p_a = 16'hF000; p_b = 16'h000F; p_op = OP_OR;
    @(negedge clk);
    p_valid = 1'b0;
    #1;
    check("pop16_out_valid", 32'(p_ovalid), 32'd1);
    check("pop16_out_y",     32'(p_y),      32'hF00F);
    check("pop16_out_pop",   32'(p_pop),    32'd8);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bitop_pipe.md
BITOP_PIPE -- requirements
Module: bitop_pipe

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 1..32.
REQ-002 Parameter ACC_INIT, default 0, WIDTH-bit accumulator value after reset and after ACC_CLR.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operand word presented.
REQ-006 in_ready  output  1  block can accept operand word this cycle.
REQ-007 in_a  input  WIDTH  operand A.
REQ-008 in_b  input  WIDTH  operand B.
REQ-009 in_op  input  3  operation select, encodings per REQ-014.
REQ-010 out_valid  output  1  result register holds a valid result.
REQ-011 out_ready  input  1  consumer accepts result this cycle.
REQ-012 out_y  output  WIDTH  registered result.
REQ-013 out_oe  output  WIDTH  registered enable mask = in_a & in_b of the producing transfer; out_err  output  1  registered illegal-op flag.

Function
REQ-014 Ops: 0 XOR a^b; 1 AND a&b; 2 OR a|b; 3 XNOR ~(a^b); 4 ACC acc^a^b, result = new acc; 5 ACC_CLR result = current acc, acc <= ACC_INIT; 6,7 illegal.
REQ-015 Transfer in = in_valid & in_ready; transfer out = out_valid & out_ready.
REQ-016 in_ready = ~out_valid | out_ready (combinational, one-deep output register, no bubble under continuous flow).
REQ-017 Latency exactly 1 cycle: transfer in at edge N -> out_y/out_oe/out_err valid after edge N.
REQ-018 On transfer in: out_y, out_oe, out_err load; out_valid <= 1.
REQ-019 On transfer out without transfer in: out_valid <= 0; out_y/out_oe/out_err hold.
REQ-020 Simultaneous transfer out and in: register replaced by new result, out_valid stays 1.
REQ-021 out_valid & ~out_ready: out_y, out_oe, out_err, out_valid held stable; in_ready = 0.
REQ-022 Accumulator updates only on accepted ACC/ACC_CLR ops; never on stall or rejected input.
REQ-023 Illegal op: out_y = 0, out_oe = in_a & in_b, out_err = 1, accumulator unchanged; out_err = 0 for legal ops.
REQ-024 All arithmetic bitwise, WIDTH bits, no carries; accumulator wraps naturally (XOR has no overflow).

Reset
REQ-025 rst=1 at edge: out_valid=0, out_y=0, out_oe=0, out_err=0, acc=ACC_INIT; takes priority over any concurrent transfer.
REQ-026 Reset mid-operation drops held result; in_ready=1 in first cycle after reset release.

Configuration
REQ-027 Macro BITOP_PIPE_POPCNT_EN defined: extra output out_pop, width $clog2(WIDTH+1), registered population count of result, loaded with out_y, reset 0.
REQ-028 Macro undefined: out_pop port absent; no popcount logic.

Structure
REQ-029 Package bitop_pkg: op encoding constants (OP_XOR..OP_ACC_CLR), op width 3.
REQ-030 One combinational sub-module bitop_alu (a, b, op, acc -> y, err, next_acc); pipeline/handshake and accumulator register in bitop_pipe.

Verification
REQ-031 WIDTH=8, a=0x5A b=0x0F op=0, out_ready=1 -> next cycle out_y=0x55, out_oe=0x0A, out_err=0.
REQ-032 op=4 a=0x01 b=0x00, then a=0x03 b=0x00 -> out_y=0x01 then 0x02; op=5 -> out_y=0x02, following op=4 a=0x10 b=0 -> 0x10.
REQ-033 out_ready=0 two cycles with new in_valid -> in_ready=0, out_y held, accumulator unchanged; out_ready=1 -> held word accepted, next word loads same edge.
REQ-034 op=6 a=0xFF b=0xF0 -> out_y=0x00, out_oe=0xF0, out_err=1, accumulator unchanged.
REQ-035 rst asserted while out_valid=1 and ACC=0x3C -> next cycle out_valid=0, all outputs 0, acc=ACC_INIT.
REQ-036 BITOP_PIPE_POPCNT_EN, WIDTH=16, op=2 a=0xF000 b=0x000F -> out_y=0xF00F, out_pop=8.
